addsub_iter_unit: RTL and testbench

//   Parametrised, multi-cycle add/subtract unit for the datapath ALU.

---
 rtl/addsub_iter_unit.sv | 122 ++++++++++++
 tb/tb_addsub_iter_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/addsub_iter_unit.sv
// addsub_iter_unit: multi-cycle add/subtract unit. It processes WIDTH-bit
// operands CHUNK bits per cycle, least-significant chunk first. A carry
// register (creg) chains ADC/SBC across operations, and the result and the
// {P,C,Z,V} flags are registered when the last chunk completes.
module addsub_iter_unit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic             carry, creg;
  logic             accept, last, cin;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH+CHUNK-1:0] acc_cat;
  logic [WIDTH-1:0] acc_next;
  logic             v_next;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: leave IDLE on start, return after the final chunk.
  // NOTE: assigning a default first keeps every path covered, so no latch
  // is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start)       state_next = BUSY;
      BUSY: if (k == K_LAST) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Output/control decode from the current state.
  always_comb begin
    busy   = (state == BUSY);
    accept = (state == IDLE) && start;
    last   = (state == BUSY) && (k == K_LAST);
  end

  // Carry-in select: ADD=0, SUB=1, ADC/SBC take the stored carry.
  always_comb begin
    case (op)
      2'b00:   cin = 1'b0;
      2'b01:   cin = 1'b1;
      default: cin = creg;
    endcase
  end

  // Chunk adder. The operand registers shift right each cycle, so the
  // current chunk is always in their low bits. The sum chunk enters the
  // accumulator from the top, so the full result has settled after N steps.
  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry};
    acc_cat   = {chunk_sum[CHUNK-1:0], acc} >> CHUNK;
    acc_next  = acc_cat[WIDTH-1:0];
    // On the final chunk the low bits of a_q/b_q hold the original MSBs.
    v_next    = (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                (acc_next[WIDTH-1] != a_q[CHUNK-1]);
  end

  // Datapath: capture operands on accept, step one chunk per busy cycle,
  // and publish the result, flags and carry on the last chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k      <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      creg   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flags  <= 4'b0000;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q   <= a;
        b_q   <= op[0] ? ~b : b;
        carry <= cin;
        k     <= '0;
      end else if (busy) begin
        a_q   <= a_q >> CHUNK;
        b_q   <= b_q >> CHUNK;
        carry <= chunk_sum[CHUNK];
        acc   <= acc_next;
        k     <= k + KW'(1);
        if (last) begin
          result <= acc_next;
          flags  <= {^acc_next, chunk_sum[CHUNK], ~|acc_next, v_next};
          creg   <= chunk_sum[CHUNK];
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_iter_unit.sv
// tb_addsub_iter_unit: directed test of addsub_iter_unit. The main instance
// uses WIDTH=8, CHUNK=4, and a second instance uses WIDTH=16, CHUNK=1.
// Every expected value is computed by hand.
module tb_addsub_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [7:0]  result;
  logic [3:0]  flags;

  logic        start16;
  logic [1:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [15:0] result16;
  logic [3:0]  flags16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addsub_iter_unit #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  addsub_iter_unit #(.WIDTH(16), .CHUNK(1)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .flags(flags16)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts an operation on the 8-bit instance and waits for done. The task
  // is entered and left 1 time unit after a rising edge. On return the
  // bench sits in the done cycle.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] exp_res, input logic [3:0] exp_flg);
    int cyc;
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, 2);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flg"}, flags, exp_flg);
    check({tag, "_busy_done"}, busy, 0);
  endtask

  initial begin
    int cyc;
    int npulse;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    start16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", result, 0);
    check("rst_flg", flags, 0);
    check("rst_busy16", busy16, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Signed overflow into the MSB.
    run_op("add7f", 2'b00, 8'h7F, 8'h01, 8'h80, 4'b1001);
    // Equal subtraction sets C (no borrow) and Z; then SBC with Creg=1.
    run_op("sub05", 2'b01, 8'h05, 8'h05, 8'h00, 4'b0110);
    run_op("sbc10", 2'b11, 8'h10, 8'h01, 8'h0F, 4'b0100);
    // Carry out of the top chunk, then a back-to-back ADC that consumes it.
    run_op("addff", 2'b00, 8'hFF, 8'h01, 8'h00, 4'b0110);
    run_op("adc00", 2'b10, 8'h00, 8'h00, 8'h01, 4'b1000);

    // A start while busy is ignored; exactly one done follows.
    start = 1'b1; op = 2'b00; a = 8'h10; b = 8'h20;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; a = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0;
    npulse = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) npulse++;
    end
    check("ign_pulses", npulse, 1);
    check("ign_res", result, 8'h30);
    check("ign_flg", flags, 4'b0000);

    // Set Creg=1 and a nonzero result, then reset mid-operation.
    run_op("sub_pre", 2'b01, 8'h05, 8'h01, 8'h04, 4'b1100);
    start = 1'b1; op = 2'b00; a = 8'h11; b = 8'h22;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;             // k = 1
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_res", result, 0);
    check("mid_rst_flg", flags, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    npulse = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) npulse++;
    end
    check("post_rst_pulses", npulse, 0);
    // A cleared Creg makes ADC 0+0 produce 0.
    run_op("adc_creg0", 2'b10, 8'h00, 8'h00, 8'h00, 4'b0010);
    run_op("add12", 2'b00, 8'h12, 8'h34, 8'h46, 4'b1000);

    // 16-bit instance with 1-bit chunks.
    start16 = 1'b1; op16 = 2'b00; a16 = 16'h8000; b16 = 16'h8000;
    @(posedge clk); #1;
    start16 = 1'b0;
    check("w16_busy", busy16, 1);
    cyc = 0;
    while (!done16 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w16_lat", cyc, 16);
    check("w16_res", result16, 16'h0000);
    check("w16_flg", flags16, 4'b0111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
